sfq_clocked_gate_n: RTL
=======================

Name: sfq_clocked_gate_n

Overview:
- Cycle-discretised, parametrised successor of the two-input clocked RSFQ AND behavioural model.
- Supports N data inputs and a selectable logic function (AND/OR/XOR/NAND).
- Every pulse is a toggle on its line, sampled on the simulation timebase `clk`. Setup/hold windows and the clock-to-output delay are in clk ticks. Timing violations are reported as flags and a counter instead of driving X.
- Sits in the same cell-library layer as the existing clocked gate models; used in cycle-based co-simulation and FPGA emulation of SFQ netlists.

Parameters:
- N_IN, 2, number of data inputs (2..8).
- MODE, 0, logic function: 0 AND, 1 OR, 2 XOR (odd parity of arrived), 3 NAND (fire unless all arrived).
- DELAY, 9, gclk-to-dout latency in ticks (1..32).
- SETUP, 3, ticks after a data pulse during which a gclk pulse is a violation (0..15; window includes the same tick).
- HOLD, 1, ticks after a gclk pulse during which a data pulse is a violation (0..15; window excludes the same tick).
- STARTUP, 4, ticks after reset release during which all input events are ignored.

Ports:
- clk, input, 1, simulation timebase.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, N_IN, data pulse lines; any transition is one pulse.
- gclk, input, 1, SFQ gate clock line; any transition is one pulse.
- dout, output, 1, output pulse line; toggles once per fired evaluation.
- arrived, output, N_IN, per-input stored-pulse state for the current gate cycle.
- err_timing, output, 1, one-tick strobe on setup or hold violation.
- err_dup, output, 1, one-tick strobe on a second pulse on an input already arrived.
- err_count, output, 16, saturating count of violation ticks.

Behaviour:
- Reset (async assert, sync release): dout=0, arrived=0, err_timing=0, err_dup=0, err_count=0, pipeline cleared.
- On reset, the registered copies of din/gclk clear and the startup counter loads STARTUP.
- Edge detect: pulse_i = din[i] ^ din_q[i]; gpulse = gclk ^ gclk_q. The registers update every tick.
- While the startup counter is nonzero, pulses are masked: no state change, no errors. Level mismatches at reset release are absorbed this way.
- Data pulse on input i, no gpulse in the same tick:
  - If arrived[i]=1, err_dup=1 and arrived stays 1.
  - Otherwise arrived[i] is set.
- gpulse at tick k:
  - fire = f(arrived | pulses in tick k) per MODE.
  - fire is shifted into a DELAY-stage pipeline; dout toggles at tick k+DELAY when the fired bit exits.
  - arrived clears to 0 at tick k. Same-tick data pulses are consumed by this evaluation and are not carried over.
- Setup: a per-input counter restarts at 0 on each pulse and saturates at SETUP+1. A gpulse while any counter <= SETUP, including same tick (counter 0), gives err_timing=1. Evaluation still proceeds.
- Hold: a counter restarts on gpulse and saturates at HOLD+1. A data pulse at 1..HOLD ticks after gpulse gives err_timing=1. The pulse is still recorded for the next cycle.
- If a data pulse is simultaneously a hold and dup violation, both strobes assert.
- err_count increments by 1 per tick in which err_timing or err_dup is high, saturating at 65535.
- Pipeline back-to-back: gpulses closer than DELAY are all retained. Each produces its own dout toggle in order; no overflow is possible.
- gpulse with nothing arrived: MODE 3 fires, MODE 0/1/2 do not. This is not an error.
- rst_n asserted mid-flight discards pending pipeline bits; no dout toggle occurs after release.

Test Plan:
- N_IN=2, MODE0: pulse din0 at t=10, din1 at t=20, gclk at t=30 -> dout 0->1 at t=39, arrived 11->00 at t=30, no errors.
- MODE0: din0 only at t=10, gclk at t=30 -> dout stays 0. Then din0+din1 and gclk at t=50 -> toggle at t=59.
- Setup violation: din1 at t=28, gclk at t=30 (SETUP=3) -> err_timing strobe at t=30, err_count=1, dout toggles at t=39 if din0 already arrived.
- Hold/dup: gclk t=40, din0 t=41 -> err_timing at t=41. din0 again at t=50 -> err_dup at t=50, err_count=2, arrived[0]=1.
- Pipeline: MODE1, din0 pulse each 3 ticks and gclk at t=30,33,36 -> dout toggles at t=39,42,45. Reset asserted at t=37 -> no toggle at t=39+, outputs 0.
- Startup: din held 1 through reset release, gclk toggles at release+2 -> no error, no fire, err_count=0.

Source files
------------

// File: rtl/sfq_clocked_gate_n.sv
// Cycle-discretised N-input clocked SFQ gate: toggle-coded pulses on din/gclk,
// selectable AND/OR/XOR/NAND evaluation, DELAY-tick output pipeline, timing flags.
module sfq_clocked_gate_n #(
  parameter int N_IN    = 2,
  parameter int MODE    = 0,
  parameter int DELAY   = 9,
  parameter int SETUP   = 3,
  parameter int HOLD    = 1,
  parameter int STARTUP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] din,
  input  logic            gclk,
  output logic            dout,
  output logic [N_IN-1:0] arrived,
  output logic            err_timing,
  output logic            err_dup,
  output logic [15:0]     err_count
);

  localparam logic [4:0]  SETUP_V   = 5'(SETUP);
  localparam logic [4:0]  SETUP_SAT = 5'(SETUP + 1);
  localparam logic [4:0]  HOLD_V    = 5'(HOLD);
  localparam logic [4:0]  HOLD_SAT  = 5'(HOLD + 1);
  localparam logic [15:0] STARTUP_V = 16'(STARTUP);

  function automatic logic eval_gate(input logic [N_IN-1:0] v);
    logic r;
    case (MODE)
      1:       r = |v;
      2:       r = ^v;
      3:       r = ~&v;
      default: r = &v;
    endcase
    return r;
  endfunction

  logic [N_IN-1:0]  din_q;
  logic             gclk_q;
  logic [15:0]      su_cnt;
  logic [4:0]       sc [N_IN];
  logic [4:0]       hc;
  logic [DELAY-1:0] fire_pipe;

  logic [N_IN-1:0]  pulse;
  logic             gpulse;
  logic             active;
  logic             setup_hit;
  logic             hold_hit;
  logic             timing_n;
  logic             dup_n;
  logic             fire_in;

  // Edge detect and violation classification for the current tick
  always_comb begin
    pulse     = din ^ din_q;
    gpulse    = gclk ^ gclk_q;
    active    = (su_cnt == 16'd0);
    setup_hit = |pulse;
    for (int i = 0; i < N_IN; i++) begin
      if (sc[i] <= SETUP_V) setup_hit = 1'b1;
    end
    hold_hit  = (|pulse) && !gpulse && (hc <= HOLD_V);
    timing_n  = active && ((gpulse && setup_hit) || hold_hit);
    dup_n     = active && !gpulse && (|(pulse & arrived));
    fire_in   = active && gpulse && eval_gate(arrived | pulse);
  end

  // State update, evaluation pipeline and output toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q      <= '0;
      gclk_q     <= 1'b0;
      su_cnt     <= STARTUP_V;
      arrived    <= '0;
      err_timing <= 1'b0;
      err_dup    <= 1'b0;
      err_count  <= 16'd0;
      fire_pipe  <= '0;
      dout       <= 1'b0;
      hc         <= HOLD_SAT;
      for (int i = 0; i < N_IN; i++) sc[i] <= SETUP_SAT;
    end else begin
      din_q      <= din;
      gclk_q     <= gclk;
      err_timing <= timing_n;
      err_dup    <= dup_n;
      if ((timing_n || dup_n) && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
      fire_pipe[0] <= fire_in;
      for (int s = 1; s < DELAY; s++) fire_pipe[s] <= fire_pipe[s-1];
      dout <= dout ^ fire_pipe[DELAY-1];
      if (!active) begin
        su_cnt <= su_cnt - 16'd1;
      end else begin
        // Same-tick data pulses are consumed by the evaluation, not carried over
        if (gpulse) begin
          arrived <= '0;
          hc      <= 5'd1;
        end else begin
          arrived <= arrived | pulse;
          hc      <= (hc == HOLD_SAT) ? hc : hc + 5'd1;
        end
        for (int i = 0; i < N_IN; i++) begin
          if (pulse[i])
            sc[i] <= 5'd1;
          else if (sc[i] != SETUP_SAT)
            sc[i] <= sc[i] + 5'd1;
        end
      end
    end
  end

endmodule
